// File: rtl/frame_upload_datapath.sv
// frame_upload_datapath: pixel-pair cache (16x16 write / 8x32 read) plus
// registered frame-address adder for the frame uploader.
// Ports: clk, reset_n (async, active-low);
//   write port  cea/ada/din; read port ceb/adb -> dout; oce (output reg only);
//   adder a/b/ce -> sum (bit ADDR_W is carry-out).
// Optional macro CACHE_OUT_REG_EN: adds an oce-gated output register after
// the read latch (read latency 2 clk). Undefined: oce unused, latency 1 clk.
module frame_upload_datapath #(
    parameter int CACHE_DEPTH_W = 16,
    parameter int ADDR_W        = 21
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             cea,
    input  logic [$clog2(CACHE_DEPTH_W)-1:0] ada,
    input  logic [15:0]                      din,
    input  logic                             ceb,
    input  logic [$clog2(CACHE_DEPTH_W)-2:0] adb,
    input  logic                             oce,
    output logic [31:0]                      dout,
    input  logic [ADDR_W-1:0]                a,
    input  logic [ADDR_W-1:0]                b,
    input  logic                             ce,
    output logic [ADDR_W:0]                  sum
);

    localparam int AW = $clog2(CACHE_DEPTH_W);

    logic [15:0]   mem [CACHE_DEPTH_W];
    logic [31:0]   rd_q;
    logic [ADDR_W:0] sum_q;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (cea) begin
            mem[ada] <= din;
        end
    end

    // Non-blocking update of mem means a same-edge read sees the old word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else if (ceb) begin
            rd_q <= {mem[{adb, 1'b1}], mem[{adb, 1'b0}]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (ce) begin
            sum_q <= {1'b0, a} + {1'b0, b};
        end
    end

    assign sum = sum_q;

`ifdef CACHE_OUT_REG_EN
    logic [31:0] out_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
        end else if (oce) begin
            out_q <= rd_q;
        end
    end

    assign dout = out_q;
`else
    logic unused_oce;

    assign unused_oce = oce;
    assign dout       = rd_q;
`endif

    logic [AW-1:0] unused_aw;

    assign unused_aw = '0;

endmodule

// File: tb/tb_frame_upload_datapath.sv
// tb_frame_upload_datapath: vector table, hand sequences and random
// traffic against a behavioural cache/adder model.
module tb_frame_upload_datapath;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cea;
    logic [3:0]  ada;
    logic [15:0] din;
    logic        ceb;
    logic [2:0]  adb;
    logic        oce;
    logic [31:0] dout;
    logic [20:0] a;
    logic [20:0] b;
    logic        ce;
    logic [21:0] sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    frame_upload_datapath dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cea     (cea),
        .ada     (ada),
        .din     (din),
        .ceb     (ceb),
        .adb     (adb),
        .oce     (oce),
        .dout    (dout),
        .a       (a),
        .b       (b),
        .ce      (ce),
        .sum     (sum)
    );

    typedef struct {
        logic        cea;
        logic [3:0]  ada;
        logic [15:0] din;
        logic        ceb;
        logic [2:0]  adb;
        logic        ce;
        logic [20:0] a;
        logic [20:0] b;
        logic        cd;
        logic [31:0] ed;
        logic        cs;
        logic [21:0] es;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic cea_i, logic [3:0] ada_i, logic [15:0] din_i,
        logic ceb_i, logic [2:0] adb_i,
        logic ce_i, logic [20:0] a_i, logic [20:0] b_i,
        logic cd_i, logic [31:0] ed_i, logic cs_i, logic [21:0] es_i);
        vec_t v;
        v.cea = cea_i; v.ada = ada_i; v.din = din_i;
        v.ceb = ceb_i; v.adb = adb_i;
        v.ce = ce_i; v.a = a_i; v.b = b_i;
        v.cd = cd_i; v.ed = ed_i; v.cs = cs_i; v.es = es_i;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cea = 1'b0; ada = '0; din = '0;
        ceb = 1'b0; adb = '0; ce = 1'b0;
    endtask

    // Behavioural model state for the random phase
    logic [15:0] m [16];
    logic [31:0] m_dout;
    logic [21:0] m_sum;

    initial begin
        reset_n = 1'b0;
        oce     = 1'b1;
        a = '0; b = '0;
        idle();
        #12;
        chk("reset_dout", dout, 32'h0);
        chk("reset_sum", {10'h0, sum}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1'b1, 4'(i), 16'(16'h1111 * (i + 1)), 1'b0, 3'd0,
                             1'b0, 21'h0, 21'h0, 1'b1, 32'h0, 1'b1, 22'h0));
        tbl.push_back(mk(1'b0, 4'd0, 16'h0, 1'b1, 3'd0, 1'b1, 21'h000100, 21'd16,
                         1'b1, 32'h22221111, 1'b1, 22'h000110));
        tbl.push_back(mk(1'b0, 4'd0, 16'h0, 1'b1, 3'd1, 1'b0, 21'h005555, 21'd3,
                         1'b1, 32'h44443333, 1'b1, 22'h000110));
        tbl.push_back(mk(1'b0, 4'd0, 16'h0, 1'b1, 3'd2, 1'b0, 21'h0ABCDE, 21'd7,
                         1'b1, 32'h66665555, 1'b1, 22'h000110));
        tbl.push_back(mk(1'b0, 4'd0, 16'h0, 1'b0, 3'd5, 1'b1, 21'h1FFFFF, 21'd1,
                         1'b1, 32'h66665555, 1'b1, 22'h200000));
        tbl.push_back(mk(1'b1, 4'd6, 16'h7777, 1'b0, 3'd0, 1'b1, 21'h1FFFFF,
                         21'h1FFFFF, 1'b1, 32'h66665555, 1'b1, 22'h3FFFFE));
        tbl.push_back(mk(1'b1, 4'd7, 16'h8888, 1'b0, 3'd0, 1'b1, 21'h0, 21'h0,
                         1'b1, 32'h66665555, 1'b1, 22'h0));
        tbl.push_back(mk(1'b0, 4'd0, 16'h0, 1'b1, 3'd3, 1'b1, 21'h012345, 21'h000400,
                         1'b1, 32'h88887777, 1'b1, 22'h012745));

        foreach (tbl[i]) begin
            cea = tbl[i].cea; ada = tbl[i].ada; din = tbl[i].din;
            ceb = tbl[i].ceb; adb = tbl[i].adb;
            ce = tbl[i].ce; a = tbl[i].a; b = tbl[i].b;
            step();
            if (tbl[i].cd) chk($sformatf("tbl%0d_dout", i), dout, tbl[i].ed);
            if (tbl[i].cs) chk($sformatf("tbl%0d_sum", i), {10'h0, sum}, {10'h0, tbl[i].es});
        end

        // Read-before-write on the same word
        idle();
        cea = 1'b1; ada = 4'd0; din = 16'hAAAA;
        step();
        cea = 1'b1; ada = 4'd1; din = 16'hBBBB;
        ceb = 1'b1; adb = 3'd0;
        step();
        chk("rbw_old", dout, 32'h2222AAAA);
        cea = 1'b0;
        step();
        chk("rbw_new", dout, 32'hBBBBAAAA);

        // Hold with ceb low while the address moves
        ceb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            adb = 3'(i + 1);
            step();
            chk($sformatf("hold%0d", i), dout, 32'hBBBBAAAA);
        end

        // Async reset mid-cycle
        chk("pre_reset_sum", {10'h0, sum}, 32'h00012745);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_dout", dout, 32'h0);
        chk("async_rst_sum", {10'h0, sum}, 32'h0);
        #1;
        reset_n = 1'b1;
        step();
        chk("post_rst_dout", dout, 32'h0);
        chk("post_rst_sum", {10'h0, sum}, 32'h0);
        ceb = 1'b1; adb = 3'd0;
        step();
        chk("mem_kept", dout, 32'hBBBBAAAA);

        // Fill every location so the model knows the whole array
        idle();
        for (int i = 0; i < 16; i++) begin
            cea = 1'b1; ada = 4'(i); din = 16'($urandom);
            m[i] = din;
            step();
        end

        m_dout = '0;
        m_sum  = '0;
        for (int n = 0; n < 300; n++) begin
            cea = 1'($urandom);
            ada = 4'($urandom);
            din = 16'($urandom);
            ceb = (n == 0) ? 1'b1 : 1'($urandom);
            adb = 3'($urandom);
            ce  = (n == 0) ? 1'b1 : 1'($urandom);
            a   = 21'($urandom);
            b   = (n % 7 == 0) ? 21'h1FFFFF : 21'($urandom_range(0, 4096));
            if (ceb) m_dout = {m[2 * adb + 1], m[2 * adb]};
            if (ce) m_sum = 22'(int'(a) + int'(b));
            if (cea) m[ada] = din;
            step();
            chk($sformatf("rnd%0d_dout", n), dout, m_dout);
            chk($sformatf("rnd%0d_sum", n), {10'h0, sum}, {10'h0, m_sum});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
